// File: rtl/sqrt_seg_display_pkg.sv
// Shared definitions for the square-root seven-segment display: conversion
// FSM states, segment patterns, blank digit positions and the double-dabble step.
package sqrt_seg_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } convState_e;

    // One iteration per bit of the 8-bit radicand
    localparam int DD_ITER = 8;

    // Cathode patterns {g,f,e,d,c,b,a}, active-low; entry 0 is the rightmost
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Digits 4,3,2 separate the radicand from the root and are never lit
    localparam logic [7:0] BLANK_MASK = 8'b0001_1100;

    // Digit positions of the lit fields
    localparam logic [2:0] POS_SQRT_UNITS = 3'd0;
    localparam logic [2:0] POS_SQRT_TENS  = 3'd1;
    localparam logic [2:0] POS_A_UNITS    = 3'd5;
    localparam logic [2:0] POS_A_TENS     = 3'd6;
    localparam logic [2:0] POS_A_HUNDREDS = 3'd7;

    // One double-dabble iteration on {bcd[11:0], bin[7:0]}: adjust each BCD
    // nibble that is 5 or more by adding 3, then shift the whole word left.
    function automatic logic [19:0] ddStep(input logic [19:0] v);
        logic [19:0] t;
        t = v;
        for (int n = 0; n < 3; n++) begin
            if (t[8 + 4*n +: 4] >= 4'd5) begin
                t[8 + 4*n +: 4] = t[8 + 4*n +: 4] + 4'd3;
            end
        end
        return {t[18:0], 1'b0};
    endfunction

    // BCD digit to cathode pattern; anything above 9 shows blank
    function automatic logic [6:0] segDecode(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_BLANK;
        if (d <= 4'd9) begin
            s = SEG_TABLE[d];
        end
        return s;
    endfunction

endpackage

// File: rtl/bin8_to_bcd3.sv
// Iterative 8-bit binary to 3-digit BCD converter (double dabble), one
// iteration per clock, with a start/busy/done handshake.
module bin8_to_bcd3
    import sqrt_seg_display_pkg::*;
(
    input  logic        clk,
    input  logic        clr_n,
    input  logic        start_i,
    input  logic [7:0]  din_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [11:0] bcd_o
);

    convState_e  state_q, state_d;
    logic        busy_q, busy_d;
    logic [19:0] shift_q, shift_d;
    logic [2:0]  count_q, count_d;

    // State and datapath registers; reset aborts any conversion in flight
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            shift_q <= 20'd0;
            count_q <= 3'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    // Next-state logic: load on start, eight shift iterations, one done cycle
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        shift_d = shift_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    shift_d = {12'd0, din_i};
                    count_d = 3'd0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_d = ddStep(shift_q);
                count_d = count_q + 3'd1;
                if (count_q == 3'(DD_ITER - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o = busy_q;
    assign done_o = (state_q == ST_DONE);
    assign bcd_o  = shift_q[19:8];

endmodule

// File: rtl/sqrt_seg_display.sv
// Eight-digit multiplexed display of a radicand (digits 7..5) and its square
// root (digits 1..0); the radicand goes through an iterative BCD converter.
module sqrt_seg_display
    import sqrt_seg_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
)(
    input  logic       clk,
    input  logic       clr_n,
    input  logic [7:0] a,
    input  logic [3:0] sqrt,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [7:0]    snapA_q, snapA_d;
    logic [3:0]    snapSqrt_q, snapSqrt_d;
    logic [11:0]   dispA_q, dispA_d;
    logic [3:0]    dispSqrtTens_q, dispSqrtTens_d;
    logic [3:0]    dispSqrtUnits_q, dispSqrtUnits_d;
    logic [CW-1:0] refreshCnt_q, refreshCnt_d;
    logic [2:0]    digitIdx_q, digitIdx_d;

    logic          convBusy;
    logic          convDone;
    logic [11:0]   convBcd;
    logic          startConv;
    logic [3:0]    sqrtTens;
    logic [3:0]    sqrtUnits;
    logic [3:0]    digitVal;

    bin8_to_bcd3 u_bcd (
        .clk     (clk),
        .clr_n   (clr_n),
        .start_i (startConv),
        .din_i   (a),
        .busy_o  (convBusy),
        .done_o  (convDone),
        .bcd_o   (convBcd)
    );

    // Start a conversion only when the converter is idle and the inputs have
    // moved away from the last snapshot; changes while busy are picked up later
    always_comb begin
        startConv = !convBusy && ({a, sqrt} != {snapA_q, snapSqrt_q});
        snapA_d    = snapA_q;
        snapSqrt_d = snapSqrt_q;
        if (startConv) begin
            snapA_d    = a;
            snapSqrt_d = sqrt;
        end
    end

    // Split the snapshot root (0..15) into decimal tens and units
    always_comb begin
        sqrtTens  = (snapSqrt_q >= 4'd10) ? 4'd1 : 4'd0;
        sqrtUnits = (snapSqrt_q >= 4'd10) ? (snapSqrt_q - 4'd10) : snapSqrt_q;
    end

    // Display registers move only on the converter's done cycle, so a
    // half-shifted result is never shown
    always_comb begin
        dispA_d         = dispA_q;
        dispSqrtTens_d  = dispSqrtTens_q;
        dispSqrtUnits_d = dispSqrtUnits_q;
        if (convDone) begin
            dispA_d         = convBcd;
            dispSqrtTens_d  = sqrtTens;
            dispSqrtUnits_d = sqrtUnits;
        end
    end

    // Free-running scan: each digit stays lit for REFRESH_DIV clocks
    always_comb begin
        refreshCnt_d = refreshCnt_q + 1'b1;
        digitIdx_d   = digitIdx_q;
        if (refreshCnt_q == CNT_MAX) begin
            refreshCnt_d = '0;
            digitIdx_d   = digitIdx_q + 3'd1;
        end
    end

    // All display-side state
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            snapA_q         <= 8'd0;
            snapSqrt_q      <= 4'd0;
            dispA_q         <= 12'd0;
            dispSqrtTens_q  <= 4'd0;
            dispSqrtUnits_q <= 4'd0;
            refreshCnt_q    <= '0;
            digitIdx_q      <= 3'd0;
        end else begin
            snapA_q         <= snapA_d;
            snapSqrt_q      <= snapSqrt_d;
            dispA_q         <= dispA_d;
            dispSqrtTens_q  <= dispSqrtTens_d;
            dispSqrtUnits_q <= dispSqrtUnits_d;
            refreshCnt_q    <= refreshCnt_d;
            digitIdx_q      <= digitIdx_d;
        end
    end

    // Select and decode the digit under the current scan index
    always_comb begin
        digitVal = 4'd0;
        case (digitIdx_q)
            POS_SQRT_UNITS: digitVal = dispSqrtUnits_q;
            POS_SQRT_TENS:  digitVal = dispSqrtTens_q;
            POS_A_UNITS:    digitVal = dispA_q[3:0];
            POS_A_TENS:     digitVal = dispA_q[7:4];
            POS_A_HUNDREDS: digitVal = dispA_q[11:8];
            default:        digitVal = 4'd0;
        endcase
        if (BLANK_MASK[digitIdx_q]) begin
            an  = 8'hFF;
            seg = SEG_BLANK;
        end else begin
            an  = ~(8'h01 << digitIdx_q);
            seg = segDecode(digitVal);
        end
    end

    assign dp   = 1'b1;
    assign busy = convBusy;

endmodule

// File: tb/tb_sqrt_seg_display.sv
// Directed self-checking bench for sqrt_seg_display with a short refresh period.
module tb_sqrt_seg_display;

    logic       clk;
    logic       clr_n;
    logic [7:0] a;
    logic [3:0] sqrt;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       busy;

    int checks;
    int errors;

    sqrt_seg_display #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .a     (a),
        .sqrt  (sqrt),
        .an    (an),
        .seg   (seg),
        .dp    (dp),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; every check is counted here
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int aVal, input int sqrtVal);
        a    = 8'(aVal);
        sqrt = 4'(sqrtVal);
    endtask

    // Hand-written segment patterns {g,f,e,d,c,b,a}, active-low
    function automatic logic [6:0] segOf(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected cathodes at a digit position for a given displayed pair
    function automatic logic [6:0] expSeg(input int pos, input int aVal, input int sqrtVal);
        case (pos)
            7: return segOf(aVal / 100);
            6: return segOf((aVal / 10) % 10);
            5: return segOf(aVal % 10);
            1: return segOf(sqrtVal / 10);
            0: return segOf(sqrtVal % 10);
            default: return 7'b1111111;
        endcase
    endfunction

    // Check whatever digit is lit right now against the expected pair
    task automatic sampleAndCheck(input string tag, input int aVal, input int sqrtVal);
        int pos;
        logic [7:0] mask;
        pos = 8;
        for (int i = 0; i < 8; i++) begin
            mask = ~(8'h01 << i);
            if (an == mask) pos = i;
        end
        checkOutput({tag, "_onehot"}, 32'($countones(~an) <= 1), 32'd1);
        checkOutput({tag, "_dp"}, 32'(dp), 32'd1);
        if (an == 8'hFF) begin
            checkOutput({tag, "_blankSeg"}, 32'(seg), 32'h7F);
        end else begin
            checkOutput($sformatf("%s_d%0d", tag, pos), 32'(seg), 32'(expSeg(pos, aVal, sqrtVal)));
        end
    endtask

    task automatic checkFrame(input string tag, input int aVal, input int sqrtVal);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            sampleAndCheck(tag, aVal, sqrtVal);
        end
    endtask

    // Follow one conversion from the negedge of its stimulus: counts busy
    // samples and the negedge on which busy is first seen low again. The
    // previous result must stay on the display meanwhile. An optional input
    // change can be injected at negedge changeAt.
    task automatic trackConversion(input string tag, input int oldA, input int oldSqrt,
                                   input int changeAt, input int newA, input int newSqrt,
                                   output int latency, output int busyCnt);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        latency = 0;
        busyCnt = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (changeAt != 0 && n == changeAt) applyStimulus(newA, newSqrt);
            if (busy) begin
                busyCnt++;
                sampleAndCheck(tag, oldA, oldSqrt);
            end else if (busyCnt > 0) begin
                latency = n;
                done = 1'b1;
            end else begin
                sampleAndCheck(tag, oldA, oldSqrt);
            end
        end
        if (!done) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Wait (bounded) until a given anode pattern is lit, then check its cathodes
    task automatic checkDigitAt(input string tag, input logic [7:0] anPat, input logic [6:0] segExp);
        int n;
        n = 0;
        while (an != anPat && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (an != anPat) checkOutput({tag, "_timeout"}, 32'(an), 32'(anPat));
        else checkOutput(tag, 32'(seg), 32'(segExp));
    endtask

    logic [7:0] scanAn [8];
    int lat;
    int bcnt;

    initial begin
        checks = 0;
        errors = 0;
        scanAn = '{8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'hDF, 8'hBF, 8'h7F};
        clr_n = 1'b0;
        applyStimulus(0, 0);

        // Reset values while clr_n is held low
        repeat (3) @(negedge clk);
        checkOutput("rst_an", 32'(an), 32'hFE);
        checkOutput("rst_seg", 32'(seg), 32'h40);
        checkOutput("rst_dp", 32'(dp), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);

        // Scan after release with zero inputs: four clocks per digit, wrap to 0
        clr_n = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) @(negedge clk);
            checkOutput($sformatf("scan_an_%0d", k), 32'(an), 32'(scanAn[(k / 4) % 8]));
            checkOutput($sformatf("scan_seg_%0d", k), 32'(seg),
                        (scanAn[(k / 4) % 8] == 8'hFF) ? 32'h7F : 32'h40);
            checkOutput($sformatf("scan_busy_%0d", k), 32'(busy), 32'd0);
            checkOutput($sformatf("scan_onehot_%0d", k), 32'($countones(~an) <= 1), 32'd1);
        end

        // 36 / 6: capture on the first edge, busy for 9 samples, done on edge 10
        @(negedge clk);
        applyStimulus(36, 6);
        trackConversion("c36", 0, 0, 0, 0, 0, lat, bcnt);
        checkOutput("c36_busyCycles", 32'(bcnt), 32'd9);
        checkOutput("c36_latency", 32'(lat), 32'd10);
        checkFrame("f36", 36, 6);

        // 255 / 15
        applyStimulus(255, 15);
        trackConversion("c255", 36, 6, 0, 0, 0, lat, bcnt);
        checkOutput("c255_busyCycles", 32'(bcnt), 32'd9);
        checkOutput("c255_latency", 32'(lat), 32'd10);
        checkFrame("f255", 255, 15);
        checkDigitAt("d7_255", 8'h7F, 7'b0100100);
        checkDigitAt("d0_255", 8'hFE, 7'b0010010);

        // 150 / 12, changed to 200 / 14 mid-shift: 150 lands first, then one
        // IDLE compare edge starts the 200 conversion, landing 10 edges later
        @(negedge clk);
        applyStimulus(150, 12);
        trackConversion("c150a", 255, 15, 4, 200, 14, lat, bcnt);
        checkOutput("c150a_busyCycles", 32'(bcnt), 32'd9);
        checkOutput("c150a_latency", 32'(lat), 32'd10);
        trackConversion("c200", 150, 12, 0, 0, 0, lat, bcnt);
        checkOutput("c200_busyCycles", 32'(bcnt), 32'd9);
        checkOutput("c200_latency", 32'(lat), 32'd10);
        checkFrame("f200", 200, 14);

        // Reset pulse in the middle of a 150 conversion
        @(negedge clk);
        applyStimulus(150, 12);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput($sformatf("pre_busy_%0d", k), 32'(busy), 32'd1);
            sampleAndCheck("pre", 200, 14);
        end
        #2 clr_n = 1'b0;
        #1;
        checkOutput("mid_an", 32'(an), 32'hFE);
        checkOutput("mid_seg", 32'(seg), 32'h40);
        checkOutput("mid_dp", 32'(dp), 32'd1);
        checkOutput("mid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        // Snapshot is zero after reset, so the first edge after release captures
        trackConversion("crst", 0, 0, 0, 0, 0, lat, bcnt);
        checkOutput("crst_busyCycles", 32'(bcnt), 32'd9);
        checkOutput("crst_latency", 32'(lat), 32'd10);
        checkFrame("frst", 150, 12);

        // Unchanged inputs never start a conversion
        applyStimulus(150, 12);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checkOutput($sformatf("same_busy_%0d", k), 32'(busy), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
